// File: rtl/vga_sync_decoder_if.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder_if
//
// Purpose : Bundles the sync inputs and the recovered-timing outputs of
//           vga_sync_decoder so that source and decoder connect through a
//           single port.
//
// Signals :
//   hSync        source -> decoder   horizontal sync, active-low pulse
//   vSync        source -> decoder   vertical sync, active-low pulse
//   x[9:0]       decoder -> sink     recovered pixel column
//   y[9:0]       decoder -> sink     recovered line
//   valid        decoder -> sink     locked and inside the active area
//   locked       decoder -> sink     decoder is in the LOCKED state
//   frame_start  decoder -> sink     one-cycle pulse per accepted frame
//   sync_err     decoder -> sink     one-cycle pulse per timing violation
//   err_count    decoder -> sink     saturating count of sync_err pulses
//
// Modports : master = video source / sink side, slave = the decoder.
// ---------------------------------------------------------------------------
interface vga_sync_decoder_if;
  logic       hSync;
  logic       vSync;
  logic [9:0] x;
  logic [9:0] y;
  logic       valid;
  logic       locked;
  logic       frame_start;
  logic       sync_err;
  logic [7:0] err_count;

  modport master (
    output hSync,
    output vSync,
    input  x,
    input  y,
    input  valid,
    input  locked,
    input  frame_start,
    input  sync_err,
    input  err_count
  );

  modport slave (
    input  hSync,
    input  vSync,
    output x,
    output y,
    output valid,
    output locked,
    output frame_start,
    output sync_err,
    output err_count
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Purpose : Recovers the pixel position (x, y) of a VGA-style stream from its
//           hSync/vSync pulses, checks the incoming timing against the
//           configured mode and reports lock status and timing errors.
//
// Ports   :
//   pix_clk   in   pixel clock, all logic on the rising edge
//   reset     in   asynchronous active-low reset
//   sync_bus  slave modport of vga_sync_decoder_if
//             (hSync/vSync in; x, y, valid, locked, frame_start, sync_err,
//              err_count out; all outputs registered)
//
// Build option:
//   VGA_SYNC_DECODER_SYNC_EN  when defined, hSync/vSync pass through a
//             2-flop synchroniser before edge detection (for sources not
//             synchronous to pix_clk); adds 2 cycles of latency, the timing
//             checks are unaffected because both syncs are delayed equally.
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_AV        = 640,
  parameter int H_FP        = 16,
  parameter int H_SP        = 96,
  parameter int H_BP        = 48,
  parameter int V_AV        = 480,
  parameter int V_FP        = 11,
  parameter int V_SP        = 2,
  parameter int V_BP        = 32,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               pix_clk,
  input  logic               reset,
  vga_sync_decoder_if.slave  sync_bus
);

  localparam int H_END    = H_AV + H_FP + H_SP + H_BP;
  localparam int V_END    = V_AV + V_FP + V_SP + V_BP;
  localparam int WD_LIMIT = 2 * H_END;
  localparam int WD_W     = $clog2(WD_LIMIT + 2);
  localparam int GF_W     = $clog2(LOCK_FRAMES + 1);

  // Counter values at which the sync edges are expected. Each edge is
  // detected while the counter still holds the value *before* the position
  // the source is presenting, hence the "-1" terms.
  localparam logic [9:0] X_AV      = 10'(H_AV);
  localparam logic [9:0] Y_AV      = 10'(V_AV);
  localparam logic [9:0] X_LAST    = 10'(H_END - 1);
  localparam logic [9:0] Y_LAST    = 10'(V_END - 1);
  localparam logic [9:0] X_HS_FALL = 10'(H_AV + H_FP - 1);
  localparam logic [9:0] X_HS_LOAD = 10'(H_AV + H_FP);
  localparam logic [9:0] X_HS_RISE = 10'(H_AV + H_FP + H_SP - 1);
  localparam logic [9:0] Y_VS_FALL = 10'(V_AV + V_FP - 1);
  localparam logic [9:0] Y_VS_LOAD = 10'(V_AV + V_FP);
  localparam logic [9:0] Y_VS_RISE = 10'(V_AV + V_FP + V_SP - 1);

  localparam logic [WD_W-1:0] WD_LIMIT_V = WD_W'(WD_LIMIT);
  localparam logic [WD_W-1:0] WD_SAT_V   = WD_W'(WD_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Sync input conditioning and edge detection (channel 0 = h, 1 = v)
  // -------------------------------------------------------------------------
  logic [1:0] sync_raw;
  logic [1:0] sync_fall;
  logic [1:0] sync_rise;

  assign sync_raw = {sync_bus.vSync, sync_bus.hSync};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic sync_cur;
      logic sync_q_reg;

`ifdef VGA_SYNC_DECODER_SYNC_EN
      logic [1:0] meta_reg;

      // Stages reset to the idle (high) level so reset release never
      // manufactures a falling edge.
      always_ff @(posedge pix_clk or negedge reset) begin
        if (!reset) begin
          meta_reg <= 2'b11;
        end else begin
          meta_reg <= {meta_reg[0], sync_raw[gi]};
        end
      end

      assign sync_cur = meta_reg[1];
`else
      assign sync_cur = sync_raw[gi];
`endif

      always_ff @(posedge pix_clk or negedge reset) begin
        if (!reset) begin
          sync_q_reg <= 1'b1;
        end else begin
          sync_q_reg <= sync_cur;
        end
      end

      // Edges compare the current level against last cycle's level.
      assign sync_fall[gi] =  sync_q_reg & ~sync_cur;
      assign sync_rise[gi] = ~sync_q_reg &  sync_cur;
    end
  endgenerate

  logic hs_fall, hs_rise, vs_fall, vs_rise;
  assign hs_fall = sync_fall[0];
  assign hs_rise = sync_rise[0];
  assign vs_fall = sync_fall[1];
  assign vs_rise = sync_rise[1];

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [9:0]        x_reg, x_next;
  logic [9:0]        y_reg, y_next;
  logic              valid_reg, valid_next;
  logic              locked_reg, locked_next;
  logic              frame_start_reg, frame_start_next;
  logic              sync_err_reg, sync_err_next;
  logic [7:0]        err_count_reg, err_count_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic [GF_W-1:0]   gf_reg, gf_next;

  // Decode signals produced by the output process
  logic in_track;
  logic chk_fail;
  logic wd_expire;
  logic err_det;
  logic frames_done;

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge pix_clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_UNLOCKED;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_UNLOCKED: begin
        if (vs_fall) state_next = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (err_det)                     state_next = ST_UNLOCKED;
        else if (vs_fall && frames_done) state_next = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (err_det) state_next = ST_UNLOCKED;
      end
      default: state_next = ST_UNLOCKED;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: output / decode logic
  // -------------------------------------------------------------------------
  always_comb begin
    in_track    = (state_reg == ST_ACQUIRE) || (state_reg == ST_LOCKED);
    chk_fail    = (hs_fall && (x_reg != X_HS_FALL)) ||
                  (hs_rise && (x_reg != X_HS_RISE)) ||
                  (vs_fall && ((x_reg != X_LAST) || (y_reg != Y_VS_FALL))) ||
                  (vs_rise && (y_reg != Y_VS_RISE));
    // Fires only on the single cycle the count first exceeds the limit;
    // the counter then parks one above so the timeout reports once.
    wd_expire   = (wd_reg == WD_LIMIT_V) && !hs_fall;
    err_det     = in_track && (chk_fail || wd_expire);
    // This vSync fall completes the last frame needed for lock.
    frames_done = (int'(gf_reg) + 1) >= LOCK_FRAMES;
    // locked follows the state with one register stage, so it drops the
    // cycle after the sync_err pulse.
    locked_next = (state_reg == ST_LOCKED);
  end

  // -------------------------------------------------------------------------
  // Datapath next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    x_next           = x_reg;
    y_next           = y_reg;
    wd_next          = wd_reg;
    gf_next          = gf_reg;
    err_count_next   = err_count_reg;
    sync_err_next    = err_det;
    frame_start_next = in_track && vs_fall && !err_det;

    // Position counters: vSync load beats hSync load beats free-running wrap.
    if (vs_fall) begin
      x_next = '0;
      y_next = Y_VS_LOAD;
    end else if (hs_fall) begin
      x_next = X_HS_LOAD;
    end else if (x_reg == X_LAST) begin
      x_next = '0;
      y_next = (y_reg == Y_LAST) ? 10'd0 : y_reg + 10'd1;
    end else begin
      x_next = x_reg + 10'd1;
    end

    // Cycles since the last hSync fall, parked at WD_SAT_V.
    if (hs_fall) begin
      wd_next = '0;
    end else if (wd_reg != WD_SAT_V) begin
      wd_next = wd_reg + 1'b1;
    end

    // Good-frame counter used only while acquiring.
    case (state_reg)
      ST_UNLOCKED: if (vs_fall)             gf_next = '0;
      ST_ACQUIRE:  if (vs_fall && !err_det) gf_next = gf_reg + 1'b1;
      default:                              gf_next = gf_reg;
    endcase

    if (err_det && (err_count_reg != 8'hFF)) begin
      err_count_next = err_count_reg + 8'd1;
    end

    // valid is built from the next-cycle position so it lines up with the
    // registered x/y it describes.
    valid_next = locked_next && (x_next < X_AV) && (y_next < Y_AV);
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge pix_clk or negedge reset) begin
    if (!reset) begin
      x_reg           <= '0;
      y_reg           <= '0;
      valid_reg       <= 1'b0;
      locked_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      err_count_reg   <= '0;
      wd_reg          <= '0;
      gf_reg          <= '0;
    end else begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      valid_reg       <= valid_next;
      locked_reg      <= locked_next;
      frame_start_reg <= frame_start_next;
      sync_err_reg    <= sync_err_next;
      err_count_reg   <= err_count_next;
      wd_reg          <= wd_next;
      gf_reg          <= gf_next;
    end
  end

  assign sync_bus.x           = x_reg;
  assign sync_bus.y           = y_reg;
  assign sync_bus.valid       = valid_reg;
  assign sync_bus.locked      = locked_reg;
  assign sync_bus.frame_start = frame_start_reg;
  assign sync_bus.sync_err    = sync_err_reg;
  assign sync_bus.err_count   = err_count_reg;

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be H_AV=640, H_FP=16, H_SP=96, H_BP=48, V_AV=480, V_FP=11, V_SP=2, V_BP=32, LOCK_FRAMES=2; derived H_END=sum of H terms (800), V_END=sum of V terms (525).
REQ-002 pix_clk  in  1  pixel clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 hSync  in  1  incoming horizontal sync, active-low pulse.
REQ-005 vSync  in  1  incoming vertical sync, active-low pulse.
REQ-006 x  out  10  recovered pixel column, 0..H_END-1.
REQ-007 y  out  10  recovered line, 0..V_END-1.
REQ-008 valid  out  1  locked & x<H_AV & y<V_AV.
REQ-009 locked  out  1  high in LOCKED state.
REQ-010 frame_start  out  1  one-cycle pulse on each accepted vSync falling edge.
REQ-011 sync_err  out  1  one-cycle pulse on any timing violation or timeout.
REQ-012 err_count  out  8  count of sync_err pulses, saturating at 255.

Function
REQ-013 hs_q/vs_q SHALL register the (optionally synchronised) sync inputs each cycle; edges = input vs. registered value.
REQ-014 x SHALL increment by 1 per cycle, wrapping H_END-1 -> 0; on wrap y SHALL increment, wrapping V_END-1 -> 0.
REQ-015 hSync falling edge SHALL load x <= H_AV+H_FP (656), in every state.
REQ-016 vSync falling edge SHALL load x <= 0, y <= H-independent V_AV+V_FP (491); this overrides the wrap increment in the same cycle.
REQ-017 Checks (evaluated only in ACQUIRE/LOCKED), violation -> sync_err: hSync fall with x != 655; hSync rise with x != 751; vSync fall with x != 799 or y != 490; vSync rise with y != 492.
REQ-018 A hSync falling-edge watchdog SHALL count cycles since the last fall; exceeding 2*H_END (1600) in ACQUIRE/LOCKED SHALL raise sync_err once and go to UNLOCKED.
REQ-019 FSM states UNLOCKED, ACQUIRE, LOCKED; UNLOCKED -> ACQUIRE on vSync fall (good_frames <= 0).
REQ-020 ACQUIRE: each error-free vSync fall SHALL increment good_frames; reaching LOCK_FRAMES -> LOCKED; any sync_err -> UNLOCKED.
REQ-021 LOCKED: any sync_err -> UNLOCKED; locked deasserts the cycle after the error pulse.
REQ-022 frame_start SHALL pulse on vSync fall in ACQUIRE/LOCKED when no check failed in that cycle.
REQ-023 err_count SHALL increment on each sync_err pulse and hold at 255.
REQ-024 Outputs SHALL be registered; input edge to x/y update latency 1 cycle (3 with REQ-029).

Reset
REQ-025 On reset low: x=0, y=0, valid=0, locked=0, frame_start=0, sync_err=0, err_count=0, state UNLOCKED, good_frames=0, watchdog=0.
REQ-026 Sync registers (hs_q, vs_q, synchroniser stages) SHALL reset to 1 (idle) so release produces no false edge.
REQ-027 Reset asserted mid-frame SHALL take effect immediately; reacquisition restarts from UNLOCKED.

Configuration
REQ-028 Macro VGA_SYNC_DECODER_SYNC_EN selects input synchronisation.
REQ-029 Defined: hSync/vSync pass through a 2-flop synchroniser before hs_q/vs_q; all timing checks unchanged, latency +2 cycles.
REQ-030 Undefined: inputs sampled directly into hs_q/vs_q (source synchronous to pix_clk).

Verification
REQ-031 Ideal 800x525 stream from reset: locked rises after 2nd error-free vSync fall following first; sync_err never pulses; err_count=0.
REQ-032 Locked, one line shortened to 799 cycles -> sync_err pulse at that hSync fall, locked drops, err_count=1, relock after 2 good frames.
REQ-033 Locked, hSync held high 2000 cycles -> sync_err once at watchdog cycle 1601, state UNLOCKED, err_count increments by 1.
REQ-034 Locked stream: valid high exactly 640x480 cycles per frame, first at x=0,y=0 ; frame_start once per 420000 cycles.
REQ-035 Force 300 errors -> err_count saturates at 255.
REQ-036 Reset pulsed mid-line while locked -> all outputs zero in reset, no sync_err after release, relock follows REQ-031.
